// File: rtl/id_fsm_pkg.sv
// Shared types and ASCII bounds for the identifier-pattern recogniser.
// The state and char-class encodings are fixed at 2 bits. State code 2'b11 is unused.
package id_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALPHA = 2'b01,
        MATCH = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        LETTER = 2'b00,
        DIGIT  = 2'b01,
        OTHER  = 2'b10
    } cclass_t;

    localparam logic [7:0] CH_A_UP   = 8'h41;
    localparam logic [7:0] CH_Z_UP   = 8'h5A;
    localparam logic [7:0] CH_A_LO   = 8'h61;
    localparam logic [7:0] CH_Z_LO   = 8'h7A;
    localparam logic [7:0] CH_0      = 8'h30;
    localparam logic [7:0] CH_9      = 8'h39;
    localparam logic [7:0] CH_USCORE = 8'h5F;

    function automatic logic in_range(input logic [7:0] c,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/id_char_class.sv
// Combinational ASCII classifier (LETTER/DIGIT/OTHER), zero latency, no backpressure.
// With ID_FSM_UNDERSCORE_EN defined, '_' counts as a letter.
module id_char_class
    import id_fsm_pkg::*;
(
    input  logic [7:0] char_i,
    output cclass_t    cls_o
);

    logic is_letter;

    always_comb begin
        is_letter = in_range(char_i, CH_A_UP, CH_Z_UP) || in_range(char_i, CH_A_LO, CH_Z_LO);
`ifdef ID_FSM_UNDERSCORE_EN
        if (char_i == CH_USCORE) begin
            is_letter = 1'b1;
        end
`endif
        cls_o = OTHER;
        if (is_letter) begin
            cls_o = LETTER;
        end else if (in_range(char_i, CH_0, CH_9)) begin
            cls_o = DIGIT;
        end
    end

endmodule

// File: rtl/id_fsm_core.sv
// Moore recogniser: out is high while the current segment ends in [A-Za-z]+[0-9]+. The output is registered and reflects the char sampled at the last edge.
// There is no backpressure because a char is consumed every clock. ID_FSM_UNDERSCORE_EN makes '_' a letter.
module id_fsm_core
    import id_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] char,
    output logic       out
);

    state_t  state_q;
    state_t  state_d;
    logic    out_q;
    cclass_t cls;

    id_char_class u_class (
        .char_i (char),
        .cls_o  (cls)
    );

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = (cls == LETTER) ? ALPHA : IDLE;
            ALPHA: begin
                if (cls == LETTER)     state_d = ALPHA;
                else if (cls == DIGIT) state_d = MATCH;
                else                   state_d = IDLE;
            end
            MATCH: begin
                if (cls == DIGIT)       state_d = MATCH;
                else if (cls == LETTER) state_d = ALPHA;
                else                    state_d = IDLE;
            end
            // Unused code 2'b11 falls back to IDLE.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= (state_d == MATCH);
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_id_fsm_core.sv
// Directed bench for id_fsm_core. Each step drives one char and checks out one time unit after the rising edge.
module tb_id_fsm_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] char;
    logic       out;

    int tests_run;
    int tests_failed;

    id_fsm_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .char  (char),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [7:0] c, input logic rst_val, input logic exp, input string tag);
        char  = c;
        rst_n = rst_val;
        @(posedge clk);
        #1;
        tests_run++;
        assert (out === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: out=%b expected=%b", tag, out, exp);
        end
    endtask

    task automatic ch(input logic [7:0] c, input logic exp, input string tag);
        step(c, 1'b1, exp, tag);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        char  = "a";
        @(posedge clk);
        step("9", 1'b0, 1'b0, "reset_state");

        // Plan 1
        ch("a", 1'b0, "p1_a");
        ch("v", 1'b0, "p1_v");
        ch("9", 1'b1, "p1_9");
        ch("1", 1'b1, "p1_1");
        ch("/", 1'b0, "p1_slash");

        // Plan 2: a bare digit run never matches
        ch(8'h00, 1'b0, "p2_nul");
        ch("9", 1'b0, "p2_9");
        ch("8", 1'b0, "p2_8");
        ch("Z", 1'b0, "p2_Z");
        ch("5", 1'b1, "p2_5");

        // Plan 3
        ch("a", 1'b0, "p3_a");
        ch("9", 1'b1, "p3_9");
        ch("b", 1'b0, "p3_b");
        ch("1", 1'b1, "p3_1");

        // Plan 4: reset in mid-match
        ch(" ", 1'b0, "p4_sep");
        ch("x", 1'b0, "p4_x");
        ch("7", 1'b1, "p4_7a");
        ch("7", 1'b1, "p4_7b");
        ch("7", 1'b1, "p4_7c");
        step("3", 1'b0, 1'b0, "p4_rst");
        ch("3", 1'b0, "p4_3_after_rst");

        // Plan 5: bytes just outside the letter and digit ranges
        ch("q", 1'b0, "p5_q1");
        ch("@", 1'b0, "p5_at");
        ch("q", 1'b0, "p5_q2");
        ch("[", 1'b0, "p5_lbr");
        ch("q", 1'b0, "p5_q3");
        ch(8'h60, 1'b0, "p5_btick");
        ch("q", 1'b0, "p5_q4");
        ch("{", 1'b0, "p5_lcb");
        ch("q", 1'b0, "p5_q5");
        ch(":", 1'b0, "p5_colon");
        ch("q", 1'b0, "p5_q6");
        ch("0", 1'b1, "p5_0");

        // High-half bytes are separators.
        ch("m", 1'b0, "hi_m");
        ch(8'hFF, 1'b0, "hi_ff");
        ch("4", 1'b0, "hi_4");
        ch("m", 1'b0, "hi_m2");
        ch(8'h80, 1'b0, "hi_80");

        // Held chars are re-sampled every cycle.
        ch("k", 1'b0, "hold_k1");
        ch("k", 1'b0, "hold_k2");
        ch("k", 1'b0, "hold_k3");
        ch("2", 1'b1, "hold_2a");
        ch("2", 1'b1, "hold_2b");
        ch("2", 1'b1, "hold_2c");
        ch("2", 1'b1, "hold_2d");

        // Plan 6: underscore build option
        ch("/", 1'b0, "p6_sep");
        ch("_", 1'b0, "p6_us1");
        ch("k", 1'b0, "p6_k");
        ch("4", 1'b1, "p6_4");
        ch("_", 1'b0, "p6_us2");
`ifdef ID_FSM_UNDERSCORE_EN
        ch("4", 1'b1, "p6_us_4");
`else
        ch("4", 1'b0, "p6_us_4");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
